// File: rtl/meas_seq_ctrl.sv
// meas_seq_ctrl: debounced start/stop key driving repeated FIFO-flush -> TX -> RE
// measurement bursts, with single/continuous modes and a per-phase timeout.
module meas_seq_ctrl #(
  parameter int DEB_CNT    = 1_000_000,
  parameter int RST_LEN    = 1000,
  parameter int RST_PSTART = 100,
  parameter int RST_PEND   = 200,
  parameter int TIMEOUT    = 1_048_576,
  parameter int BURST_W    = 8
) (
  input  logic               clk_100,
  input  logic               rst_n,
  input  logic               key_in,
  input  logic               mode_cont,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               overTx,
  input  logic               overRe,
  output logic               run_led,
  output logic               beginSignal,
  output logic               enTx,
  output logic               enRe,
  output logic               fifo_rst,
  output logic               busy,
  output logic [BURST_W-1:0] cycle_cnt,
  output logic               err_timeout
);
  localparam int DW = $clog2(DEB_CNT + 1);
  localparam int PW = $clog2((TIMEOUT > RST_LEN ? TIMEOUT : RST_LEN) + 1);
  typedef enum logic [1:0] {IDLE, RST, TX, RE} st_t;
  st_t st_q, st_d;
  logic [DW-1:0] deb_q;
  logic [PW-1:0] ph_q, ph_d;
  logic [BURST_W-1:0] cnt_q, cnt_d, blen_q, blen_d;
  logic k1_q, k2_q, smp_q, press_q, tick;
  logic run_q, run_d, cont_q, cont_d, err_q, err_d;
  logic tx_q, tx_d, re_q, re_d, fr_q, fr_d, busy_q, busy_d, beg_q;
  logic tmo, last, ack, start;
  assign tick = deb_q == DW'(DEB_CNT - 1);
  always_ff @(posedge clk_100 or negedge rst_n)
    if (!rst_n) begin
      k1_q    <= 1'b1;
      k2_q    <= 1'b1;
      smp_q   <= 1'b1;
      press_q <= 1'b0;
      deb_q   <= '0;
      st_q    <= IDLE;
      ph_q    <= '0;
      run_q   <= 1'b0;
      cnt_q   <= '0;
      blen_q  <= '0;
      cont_q  <= 1'b0;
      err_q   <= 1'b0;
      tx_q    <= 1'b0;
      re_q    <= 1'b0;
      beg_q   <= 1'b0;
      fr_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      k1_q    <= key_in;
      k2_q    <= k1_q;
      deb_q   <= tick ? '0 : deb_q + 1'b1;
      smp_q   <= tick ? k2_q : smp_q;
      press_q <= tick & smp_q & ~k2_q;
      st_q    <= st_d;
      ph_q    <= ph_d;
      run_q   <= run_d;
      cnt_q   <= cnt_d;
      blen_q  <= blen_d;
      cont_q  <= cont_d;
      err_q   <= err_d;
      tx_q    <= tx_d;
      re_q    <= re_d;
      beg_q   <= tx_d | re_d;
      fr_q    <= fr_d;
      busy_q  <= busy_d;
    end
  // a stop press outranks a timeout, which outranks phase completion
  always_comb begin
    tmo  = TIMEOUT != 0 && (st_q == TX || st_q == RE) && ph_q == PW'(TIMEOUT - 1);
    last = ({1'b0, cnt_q} + 1'b1) >= {1'b0, blen_q};
    ack  = st_q == RE && overRe && !press_q && !tmo;
    st_d = st_q;
    if (press_q && st_q != IDLE) st_d = IDLE;
    else if (tmo) st_d = IDLE;
    else
      case (st_q)
        IDLE:    st_d = run_q ? RST : IDLE;
        RST:     st_d = ph_q == PW'(RST_LEN - 1) ? TX : RST;
        TX:      st_d = overTx ? RE : TX;
        default: st_d = !overRe ? RE : (last && !cont_q) ? IDLE : RST;
      endcase
  end
  always_comb begin
    start  = st_q == IDLE && st_d == RST;
    ph_d   = (st_d != st_q || st_d == IDLE) ? '0 : ph_q + 1'b1;
    run_d  = press_q ? ~run_q : (tmo || (ack && last && !cont_q)) ? 1'b0 : run_q;
    cnt_d  = start ? '0 : !ack ? cnt_q : (last && cont_q) ? '0 : cnt_q + 1'b1;
    blen_d = start ? (burst_len == '0 ? BURST_W'(1) : burst_len) : blen_q;
    cont_d = start ? mode_cont : cont_q;
    err_d  = start ? 1'b0 : (tmo && !press_q) ? 1'b1 : err_q;
    tx_d   = st_d == TX;
    re_d   = st_d == RE;
    busy_d = st_d != IDLE;
    fr_d   = st_d == RST && ph_d >= PW'(RST_PSTART) && ph_d < PW'(RST_PEND);
  end
  assign run_led     = ~run_q;
  assign beginSignal = beg_q;
  assign enTx        = tx_q;
  assign enRe        = re_q;
  assign fifo_rst    = fr_q;
  assign busy        = busy_q;
  assign cycle_cnt   = cnt_q;
  assign err_timeout = err_q;
endmodule

// File: tb/tb_meas_seq_ctrl.sv
// tb_meas_seq_ctrl: randomized bench for meas_seq_ctrl, checked every cycle against
// a phase/time-in-phase model of the sequencer plus literal scenario expectations.
module tb_meas_seq_ctrl;
  localparam int DEB = 4, RL = 20, PS = 2, PE = 5, TO = 50, BW = 8;
  logic clk_100 = 0, rst_n = 0, key_in = 1, mode_cont = 0;
  logic [BW-1:0] burst_len = 1;
  logic auto_ov = 0, tx_a = 0, re_a = 0, tx_m = 0, re_m = 0;
  logic overTx, overRe;
  logic run_led, beginSignal, enTx, enRe, fifo_rst, busy, err_timeout;
  logic [BW-1:0] cycle_cnt;
  int checks = 0, errors = 0;
  int fifo_hi = 0, tx_len = 0;
  assign overTx = auto_ov ? tx_a : tx_m;
  assign overRe = auto_ov ? re_a : re_m;
  always #5 clk_100 = ~clk_100;

  meas_seq_ctrl #(.DEB_CNT(DEB), .RST_LEN(RL), .RST_PSTART(PS), .RST_PEND(PE),
                  .TIMEOUT(TO), .BURST_W(BW)) dut (
    .clk_100(clk_100), .rst_n(rst_n), .key_in(key_in), .mode_cont(mode_cont),
    .burst_len(burst_len), .overTx(overTx), .overRe(overRe), .run_led(run_led),
    .beginSignal(beginSignal), .enTx(enTx), .enRe(enRe), .fifo_rst(fifo_rst),
    .busy(busy), .cycle_cnt(cycle_cnt), .err_timeout(err_timeout));

  // model: phase 0 idle, 1 flush, 2 tx, 3 re; m_t = clocks already spent in phase
  int m_st = 0, m_t = 0, m_cnt = 0, m_blen = 1, ec = 0, nst;
  bit m_run = 0, m_err = 0, m_cont = 0, m_press = 0, m_samp = 1, kd1 = 1, kd2 = 1, pr;
  always @(posedge clk_100 or negedge rst_n)
    if (!rst_n) begin
      m_st = 0; m_t = 0; m_cnt = 0; m_blen = 1; ec = 0;
      m_run = 0; m_err = 0; m_cont = 0; m_press = 0; m_samp = 1; kd1 = 1; kd2 = 1;
    end else begin
      pr = m_press;
      nst = m_st;
      if (m_st != 0 && pr) begin nst = 0; m_run = 0; end
      else if (m_st == 0) begin
        if (m_run) begin
          nst = 1; m_cnt = 0; m_err = 0; m_cont = mode_cont;
          m_blen = (burst_len == 0) ? 1 : int'(burst_len);
        end
        if (pr) m_run = !m_run;
      end
      else if (m_st >= 2 && m_t + 1 == TO) begin nst = 0; m_err = 1; m_run = 0; end
      else if (m_st == 1) begin if (m_t + 1 == RL) nst = 2; end
      else if (m_st == 2) begin if (overTx) nst = 3; end
      else if (overRe) begin
        m_cnt++;
        if (m_cnt < m_blen) nst = 1;
        else if (m_cont) begin m_cnt = 0; nst = 1; end
        else begin nst = 0; m_run = 0; end
      end
      m_t = (nst == m_st) ? m_t + 1 : 0;
      m_st = nst;
      // every DEB-th edge samples the key level from two edges earlier
      if (ec % DEB == DEB - 1) begin m_press = m_samp && !kd2; m_samp = kd2; end
      else m_press = 0;
      kd2 = kd1; kd1 = key_in;
      ec++;
    end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_100) begin
    if (fifo_rst) fifo_hi++;
    if (enTx) tx_len++;
    tx_a <= ($urandom_range(0, 3) == 0);
    re_a <= ($urandom_range(0, 3) == 0);
    if (rst_n) begin
      chk("busy", busy, m_st != 0);
      chk("enTx", enTx, m_st == 2);
      chk("enRe", enRe, m_st == 3);
      chk("beginSignal", beginSignal, m_st >= 2);
      chk("fifo_rst", fifo_rst, m_st == 1 && m_t >= PS && m_t < PE);
      chk("run_led", run_led, !m_run);
      chk("cycle_cnt", cycle_cnt, m_cnt);
      chk("err_timeout", err_timeout, m_err);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_100);
  endtask
  task automatic press();
    key_in = 0; cyc(10); key_in = 1; cyc(10);
  endtask
  function automatic bit sig(input int s);
    return s == 0 ? busy : s == 1 ? enTx : s == 2 ? enRe : fifo_rst;
  endfunction
  task automatic wait_sig(input string name, input int s, input bit v, input int lim);
    int n = 0;
    while (sig(s) != v && n < lim) begin cyc(1); n++; end
    chk(name, sig(s), v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, t0, n;
    cyc(3);
    chk("rst_run_led", run_led, 1);
    chk("rst_busy", busy, 0);
    chk("rst_fifo", fifo_rst, 0);
    chk("rst_entx", enTx, 0);
    chk("rst_cnt", cycle_cnt, 0);
    chk("rst_err", err_timeout, 0);
    rst_n = 1;
    cyc(4);
    // single burst of one, overTx/overRe 10 clocks into their phases
    f0 = fifo_hi;
    press();
    wait_sig("t1_entx", 1, 1, 60);
    cyc(10); tx_m = 1; cyc(1); tx_m = 0;
    wait_sig("t1_enre", 2, 1, 5);
    cyc(10); re_m = 1; cyc(1); re_m = 0; cyc(1);
    chk("t1_fifo_clks", fifo_hi - f0, 3);
    chk("t1_cnt", cycle_cnt, 1);
    chk("t1_busy", busy, 0);
    chk("t1_led", run_led, 1);
    // single burst of three
    burst_len = 3; auto_ov = 1; f0 = fifo_hi;
    press();
    burst_len = 7;
    wait_sig("t2_idle", 0, 0, 1500);
    chk("t2_fifo_clks", fifo_hi - f0, 9);
    chk("t2_cnt", cycle_cnt, 3);
    // continuous bursts of two, then stop
    mode_cont = 1; burst_len = 2;
    press();
    cyc(300);
    chk("t3_running", busy, 1);
    press();
    chk("t3_busy", busy, 0);
    chk("t3_entx", enTx, 0);
    chk("t3_enre", enRe, 0);
    chk("t3_fifo", fifo_rst, 0);
    chk("t3_led", run_led, 1);
    // TX timeout
    mode_cont = 0; burst_len = 1; auto_ov = 0; t0 = tx_len;
    press();
    wait_sig("t4_idle", 0, 0, 200);
    chk("t4_err", err_timeout, 1);
    chk("t4_led", run_led, 1);
    chk("t4_tx_clks", tx_len - t0, TO);
    press();
    chk("t4_err_clr", err_timeout, 0);
    chk("t4_restart", busy, 1);
    press();
    chk("t4_stopped", busy, 0);
    // glitch lying entirely between key samples
    n = 0;
    while (ec % DEB != 2 && n < 8) begin cyc(1); n++; end
    key_in = 0; cyc(2); key_in = 1; cyc(12);
    chk("t5_glitch_busy", busy, 0);
    chk("t5_glitch_led", run_led, 1);
    // stop press coinciding with overRe
    burst_len = 3;
    press();
    wait_sig("t5_entx", 1, 1, 60);
    tx_m = 1; cyc(1); tx_m = 0;
    wait_sig("t5_enre", 2, 1, 3);
    key_in = 0; n = 0;
    while (!m_press && n < 20) begin cyc(1); n++; end
    re_m = 1; cyc(1); re_m = 0;
    chk("t5_busy", busy, 0);
    chk("t5_cnt", cycle_cnt, 0);
    chk("t5_enre_off", enRe, 0);
    key_in = 1; cyc(12);
    // async reset while the FIFO reset pulse is high
    auto_ov = 1; burst_len = 2;
    key_in = 0;
    wait_sig("t6_fifo_hi", 3, 1, 40);
    #2 rst_n = 0;
    #1;
    chk("t6_fifo", fifo_rst, 0);
    chk("t6_busy", busy, 0);
    chk("t6_led", run_led, 1);
    chk("t6_cnt", cycle_cnt, 0);
    key_in = 1; cyc(2); rst_n = 1; cyc(2);
    chk("t6_idle", busy, 0);
    // random runs
    for (int i = 0; i < 8; i++) begin
      mode_cont = 1'($urandom_range(0, 1));
      burst_len = BW'($urandom_range(0, 4));
      press();
      burst_len = BW'($urandom_range(0, 255));
      cyc($urandom_range(20, 300));
      if (busy) press();
      wait_sig("rnd_idle", 0, 0, 400);
      cyc($urandom_range(1, 10));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
